// File: rtl/cpu_pkg.sv
// cpu_pkg: shared CPU front-end types and constants.
package cpu_pkg;

    // Fetch unit control states
    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWait,
        StHold
    } fetch_state_e;

    // PC reported on id_pc after reset
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;

    // Instruction fetches must be word aligned
    function automatic logic is_misaligned(input logic [1:0] pc_lsb);
        return pc_lsb != 2'b00;
    endfunction

endpackage

// File: rtl/inst_fetch.sv
// inst_fetch: instruction fetch stage with a single outstanding memory request,
// a one-entry output register towards decode and redirect (flush) handling.
// Optional macro INST_FETCH_ALIGN_CHECK_EN blocks fetches from misaligned PCs and
// raises a sticky fault; without it fault is tied low.
module inst_fetch
    import cpu_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_in,
    output logic              pc_ena,
    input  logic              redirect,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [ADDR_W-1:0] imem_rdata,
    output logic              id_valid,
    input  logic              id_ready,
    output logic [ADDR_W-1:0] id_inst,
    output logic [ADDR_W-1:0] id_pc,
    output logic              fault
);

    fetch_state_e      state_q, state_d;
    logic              drop_q, drop_d;
    logic [ADDR_W-1:0] tag_q, tag_d;
    logic              id_valid_q, id_valid_d;
    logic [ADDR_W-1:0] id_inst_q, id_inst_d;
    logic [ADDR_W-1:0] id_pc_q, id_pc_d;
    logic              pc_ena_q, pc_ena_d;
    logic              fault_q, fault_d;
    logic              misaligned;

`ifdef INST_FETCH_ALIGN_CHECK_EN
    assign misaligned = is_misaligned(pc_in[1:0]);
`else
    assign misaligned = 1'b0;
`endif

    // A redirect cycle carries a stale pc_in, so no request is offered then
    assign imem_req  = (state_q == StReq) && !redirect && !misaligned;
    assign imem_addr = pc_in;

    assign pc_ena   = pc_ena_q;
    assign id_valid = id_valid_q;
    assign id_inst  = id_inst_q;
    assign id_pc    = id_pc_q;
    assign fault    = fault_q;

    // Next-state and registered-output computation for the fetch FSM
    always_comb begin
        state_d    = state_q;
        drop_d     = drop_q;
        tag_d      = tag_q;
        id_valid_d = id_valid_q;
        id_inst_d  = id_inst_q;
        id_pc_d    = id_pc_q;
        pc_ena_d   = 1'b0;
        fault_d    = fault_q;

        unique case (state_q)
            StIdle: begin
                state_d = StReq;
            end
            StReq: begin
                if (misaligned && !redirect) begin
                    fault_d = 1'b1;
                end
                if (imem_req && imem_gnt) begin
                    tag_d   = pc_in;
                    state_d = StWait;
                end
            end
            StWait: begin
                if (redirect) begin
                    // A response in the same cycle is the one being discarded
                    if (imem_rvalid) begin
                        drop_d  = 1'b0;
                        state_d = StReq;
                    end else begin
                        drop_d = 1'b1;
                    end
                end else if (imem_rvalid) begin
                    if (drop_q) begin
                        drop_d  = 1'b0;
                        state_d = StReq;
                    end else begin
                        id_inst_d  = imem_rdata;
                        id_pc_d    = tag_q;
                        id_valid_d = 1'b1;
                        pc_ena_d   = 1'b1;
                        state_d    = StHold;
                    end
                end
            end
            StHold: begin
                if (redirect || id_ready) begin
                    id_valid_d = 1'b0;
                    state_d    = StReq;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            drop_q     <= 1'b0;
            tag_q      <= RESET_PC;
            id_valid_q <= 1'b0;
            id_inst_q  <= '0;
            id_pc_q    <= RESET_PC;
            pc_ena_q   <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            drop_q     <= drop_d;
            tag_q      <= tag_d;
            id_valid_q <= id_valid_d;
            id_inst_q  <= id_inst_d;
            id_pc_q    <= id_pc_d;
            pc_ena_q   <= pc_ena_d;
            fault_q    <= fault_d;
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: directed vector table, hand-written reset/alignment sequences and a
// randomized run checked against a transaction-level scoreboard of the fetch unit.
module tb_inst_fetch;

    localparam logic [31:0] RPC = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        rst, redirect, imem_gnt, imem_rvalid, id_ready;
    logic        pc_ena, imem_req, id_valid, fault;
    logic [31:0] pc_in, imem_rdata, imem_addr, id_inst, id_pc;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    inst_fetch #(
        .ADDR_W  (32),
        .RESET_PC(RPC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pc_in      (pc_in),
        .pc_ena     (pc_ena),
        .redirect   (redirect),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_gnt   (imem_gnt),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .id_valid   (id_valid),
        .id_ready   (id_ready),
        .id_inst    (id_inst),
        .id_pc      (id_pc),
        .fault      (fault)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs just after the rising edge, return at the falling edge
    task automatic cyc(input bit r, input logic [31:0] p, input bit g, input bit rv,
                       input logic [31:0] rd, input bit rdy, input bit rdr);
        @(posedge clk);
        #1;
        rst = r; pc_in = p; imem_gnt = g; imem_rvalid = rv;
        imem_rdata = rd; id_ready = rdy; redirect = rdr;
        @(negedge clk);
    endtask

    typedef struct {
        bit          rst;
        logic [31:0] pc;
        bit          gnt;
        bit          rv;
        logic [31:0] rd;
        bit          rdy;
        bit          redir;
        bit          chk;
        bit          e_req;
        bit          e_valid;
        bit          e_pcena;
        bit          cd;
        logic [31:0] e_inst;
        logic [31:0] e_pc;
    } vec_t;

    vec_t tab[$];

    task automatic add(input bit r, input logic [31:0] p, input bit g, input bit rv,
                       input logic [31:0] rd, input bit rdy, input bit rdr, input bit c,
                       input bit er, input bit ev, input bit ep, input bit cd,
                       input logic [31:0] ei, input logic [31:0] epc);
        vec_t v;
        v.rst = r; v.pc = p; v.gnt = g; v.rv = rv; v.rd = rd; v.rdy = rdy; v.redir = rdr;
        v.chk = c; v.e_req = er; v.e_valid = ev; v.e_pcena = ep; v.cd = cd;
        v.e_inst = ei; v.e_pc = epc;
        tab.push_back(v);
    endtask

    // Memory contents seen by the random run
    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_0F0F;
    endfunction

    logic [31:0] pc_r, o_addr;
    logic [31:0] q_pc[$];
    logic [31:0] q_inst[$];
    bit          outst, killed, pcena_exp, pushed, exp_req;
    int          cnt, delivered;

    initial begin
        rst = 1'b1; pc_in = RPC; imem_gnt = 1'b0; imem_rvalid = 1'b0;
        imem_rdata = '0; id_ready = 1'b1; redirect = 1'b0;

        // r  pc            g  rv rd            rdy rdr  chk req val pce cd inst          pc
        add(1, RPC,          0, 0, 0,            1, 0,   0,  0,  0,  0,  0, 0,            0);
        add(1, RPC,          0, 0, 0,            1, 0,   1,  0,  0,  0,  1, 0,            RPC);
        add(0, RPC,          0, 0, 0,            1, 0,   1,  0,  0,  0,  1, 0,            RPC);
        add(0, RPC,          1, 0, 0,            1, 0,   1,  1,  0,  0,  1, 0,            RPC);
        add(0, RPC,          0, 1, 32'h2008_0005, 0, 0,  1,  0,  0,  0,  1, 0,            RPC);
        add(0, RPC,          0, 0, 0,            0, 0,   1,  0,  1,  1,  1, 32'h2008_0005, RPC);
        for (int i = 0; i < 4; i++)
            add(0, RPC + 4,  1, 0, 0,            0, 0,   1,  0,  1,  0,  1, 32'h2008_0005, RPC);
        add(0, RPC + 4,      0, 0, 0,            1, 0,   1,  0,  1,  0,  1, 32'h2008_0005, RPC);
        add(0, RPC + 4,      0, 0, 0,            1, 0,   1,  1,  0,  0,  0, 0,            0);
        add(0, RPC + 4,      1, 0, 0,            1, 0,   1,  1,  0,  0,  0, 0,            0);
        add(0, RPC + 4,      0, 0, 0,            1, 1,   1,  0,  0,  0,  0, 0,            0);
        add(0, 32'h0040_0100, 0, 1, 32'hDEAD_BEEF, 1, 0, 1,  0,  0,  0,  0, 0,            0);
        add(0, 32'h0040_0100, 1, 0, 0,           1, 0,   1,  1,  0,  0,  0, 0,            0);
        add(0, 32'h0040_0100, 0, 1, 32'h1111_2222, 1, 1, 1,  0,  0,  0,  0, 0,            0);
        add(0, 32'h0040_0200, 0, 1, 32'hBAD0_0BAD, 1, 0, 1,  1,  0,  0,  0, 0,            0);
        add(0, 32'h0040_0200, 1, 0, 0,           1, 0,   1,  1,  0,  0,  0, 0,            0);
        add(0, 32'h0040_0200, 0, 1, 32'h3333_4444, 1, 0, 1,  0,  0,  0,  0, 0,            0);
        add(0, 32'h0040_0200, 0, 0, 0,           1, 1,   1,  0,  1,  1,  1, 32'h3333_4444,
            32'h0040_0200);
        add(0, 32'h0040_0300, 0, 0, 0,           1, 0,   1,  1,  0,  0,  0, 0,            0);

        foreach (tab[i]) begin
            cyc(tab[i].rst, tab[i].pc, tab[i].gnt, tab[i].rv, tab[i].rd, tab[i].rdy,
                tab[i].redir);
            if (tab[i].chk) begin
                chk($sformatf("v%0d_req", i), imem_req, tab[i].e_req);
                chk($sformatf("v%0d_valid", i), id_valid, tab[i].e_valid);
                chk($sformatf("v%0d_pcena", i), pc_ena, tab[i].e_pcena);
                chk($sformatf("v%0d_fault", i), fault, 0);
                if (tab[i].e_req) chk($sformatf("v%0d_addr", i), imem_addr, tab[i].pc);
                if (tab[i].cd) begin
                    chk($sformatf("v%0d_inst", i), id_inst, tab[i].e_inst);
                    chk($sformatf("v%0d_pc", i), id_pc, tab[i].e_pc);
                end
            end
        end

        // Reset while a request is outstanding; late responses must be ignored
        cyc(1, RPC, 0, 0, 0, 1, 0);
        cyc(1, RPC, 0, 0, 0, 1, 0);
        cyc(0, 32'h0040_0040, 0, 0, 0, 1, 0);
        cyc(0, 32'h0040_0040, 1, 0, 0, 1, 0);
        chk("mid_req", imem_req, 1);
        cyc(1, 32'h0040_0040, 0, 0, 0, 1, 0);
        cyc(0, 32'h0040_0040, 0, 1, 32'h7777_7777, 1, 0);
        chk("mid_idle_req", imem_req, 0);
        chk("mid_idle_valid", id_valid, 0);
        chk("mid_idle_pc", id_pc, RPC);
        cyc(0, 32'h0040_0040, 0, 1, 32'h7777_7777, 1, 0);
        chk("mid_req2", imem_req, 1);
        cyc(0, 32'h0040_0040, 0, 0, 0, 1, 0);
        chk("mid_late_valid", id_valid, 0);
        chk("mid_late_pcena", pc_ena, 0);
        chk("mid_late_req", imem_req, 1);

        // Misaligned PC handling
        cyc(1, RPC, 0, 0, 0, 1, 0);
        cyc(1, RPC, 0, 0, 0, 1, 0);
        cyc(0, 32'h0040_0002, 1, 0, 0, 1, 0);
        cyc(0, 32'h0040_0002, 1, 0, 0, 1, 0);
`ifdef INST_FETCH_ALIGN_CHECK_EN
        chk("al_req0", imem_req, 0);
        cyc(0, 32'h0040_0002, 1, 0, 0, 1, 0);
        chk("al_req1", imem_req, 0);
        chk("al_fault", fault, 1);
        cyc(0, 32'h0040_0002, 1, 0, 0, 1, 1);
        chk("al_redir_req", imem_req, 0);
        cyc(0, 32'h0040_0004, 1, 0, 0, 1, 0);
        chk("al_resume_req", imem_req, 1);
        chk("al_resume_addr", imem_addr, 32'h0040_0004);
        chk("al_sticky", fault, 1);
        cyc(0, 32'h0040_0004, 0, 1, 32'hCAFE_0001, 1, 0);
        cyc(0, 32'h0040_0008, 0, 0, 0, 1, 0);
        chk("al_valid", id_valid, 1);
        chk("al_pc", id_pc, 32'h0040_0004);
        chk("al_inst", id_inst, 32'hCAFE_0001);
`else
        chk("al_req", imem_req, 1);
        chk("al_addr", imem_addr, 32'h0040_0002);
        cyc(0, 32'h0040_0002, 0, 0, 0, 1, 0);
        chk("al_fault", fault, 0);
`endif

        // Randomized run against the scoreboard
        cyc(1, RPC, 0, 0, 0, 1, 0);
        cyc(1, RPC, 0, 0, 0, 1, 0);
        pc_r = RPC; outst = 0; killed = 0; pcena_exp = 0; cnt = 0; delivered = 0;
        o_addr = '0;
        for (int k = 0; k < 3000; k++) begin
            @(posedge clk);
            #1;
            rst = 1'b0;
            redirect = ($urandom_range(0, 7) == 0);
            id_ready = ($urandom_range(0, 2) != 0);
            imem_gnt = ($urandom_range(0, 1) == 1);
            if (outst) begin
                imem_rvalid = (cnt == 0);
                imem_rdata  = memf(o_addr);
            end else begin
                imem_rvalid = ($urandom_range(0, 7) == 0);
                imem_rdata  = $urandom;
            end
            pc_in = pc_r;
            @(negedge clk);

            exp_req = (k > 0) && !outst && (q_pc.size() == 0) && !redirect;
            chk("rnd_req", imem_req, exp_req);
            if (imem_req) chk("rnd_addr", imem_addr, pc_in);
            chk("rnd_valid", id_valid, q_pc.size() != 0);
            if (id_valid && q_pc.size() != 0) begin
                chk("rnd_pc", id_pc, q_pc[0]);
                chk("rnd_inst", id_inst, q_inst[0]);
            end
            chk("rnd_pcena", pc_ena, pcena_exp);
            chk("rnd_fault", fault, 0);

            pushed = 0;
            if (q_pc.size() != 0 && (id_ready || redirect)) begin
                void'(q_pc.pop_front());
                void'(q_inst.pop_front());
            end
            if (outst) begin
                if (imem_rvalid) begin
                    if (!killed && !redirect) begin
                        q_pc.push_back(o_addr);
                        q_inst.push_back(memf(o_addr));
                        pushed = 1;
                        delivered++;
                    end
                    outst = 0;
                end else begin
                    if (redirect) killed = 1;
                    cnt--;
                end
            end else if (exp_req && imem_gnt) begin
                outst  = 1;
                killed = 0;
                o_addr = pc_r;
                cnt    = $urandom_range(0, 2);
            end
            if (redirect) pc_r = RPC + ($urandom_range(0, 255) << 2);
            else if (pcena_exp) pc_r = pc_r + 4;
            pcena_exp = pushed;
        end
        chk("rnd_live", delivered > 50, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
